// File: rtl/id_ex_reg.sv
// Purpose : ID/EX pipeline register with EX/MEM operand forwarding and load-use bubble insertion.
// Latency : one cycle from ID inputs to ex_* outputs; stall_req is combinational (zero latency).
// Backpr. : hold_i freezes all contents; flush_i (wins over hold) and load-use stalls load a bubble.
//
// Ports:
//   clk, rst_n          - rising-edge clock, async active-low reset (reset = bubble state)
//   flush_i, hold_i     - kill the instruction being captured / freeze the register
//   id_*                - decoded op, operands, source/destination regs and flags from ID
//   ex_res              - result currently produced by EX (forward source, highest priority)
//   mem_wreg/we/res     - MEM-stage writeback (second forward source)
//   ex_*                - registered op/operands/flags presented to the EX units
//   ex_valid            - 1 = real instruction, 0 = bubble
//   stall_req           - load-use hazard; front end holds PC and IF/ID
module id_ex_reg #(
    parameter int OP_W   = 8,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic [OP_W-1:0]   id_op,
    input  logic [DATA_W-1:0] id_src0,
    input  logic [DATA_W-1:0] id_src1,
    input  logic [REG_AW-1:0] id_rs0_addr,
    input  logic              id_rs0_rd,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic              id_rs1_rd,
    input  logic [REG_AW-1:0] id_wreg,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_res,
    output logic [OP_W-1:0]   ex_op,
    output logic [DATA_W-1:0] ex_src0,
    output logic [DATA_W-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_wreg,
    output logic              ex_we,
    output logic              ex_is_load,
    output logic              ex_valid,
    output logic              stall_req
);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] src0;
        logic [DATA_W-1:0] src1;
        logic [REG_AW-1:0] wreg;
        logic              we;
        logic              is_load;
        logic              valid;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t stage_q;
    stage_t stage_d;

    // An instruction in EX can forward only when its result is ready this
    // cycle, i.e. it is a valid, writing, non-load instruction.
    logic ex_fwd_ok;
    assign ex_fwd_ok = ex_valid & ex_we & ~ex_is_load;

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic              rd,
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] src
    );
        logic [DATA_W-1:0] val;
        val = src;
        // Register 0 is hard-wired and immediates are never forwarded.
        if (rd && (addr != '0)) begin
            if (ex_fwd_ok && (addr == ex_wreg)) begin
                val = ex_res;
            end else if (mem_we && (addr == mem_wreg)) begin
                val = mem_res;
            end
        end
        return val;
    endfunction

    logic [DATA_W-1:0] fwd_src0;
    logic [DATA_W-1:0] fwd_src1;

    always_comb begin
        fwd_src0 = fwd_sel(id_rs0_rd, id_rs0_addr, id_src0);
        fwd_src1 = fwd_sel(id_rs1_rd, id_rs1_addr, id_src1);
    end

    // Load data is not available until MEM, so a consumer directly behind a
    // load must wait exactly one cycle and then picks the value up from MEM.
    logic rs0_hit;
    logic rs1_hit;
    assign rs0_hit   = id_rs0_rd & (id_rs0_addr == ex_wreg);
    assign rs1_hit   = id_rs1_rd & (id_rs1_addr == ex_wreg);
    assign stall_req = ex_valid & ex_is_load & ex_we & (ex_wreg != '0) & (rs0_hit | rs1_hit);

    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = BUBBLE;
        end else if (hold_i) begin
            stage_d = stage_q;
        end else if (stall_req) begin
            stage_d = BUBBLE;
        end else begin
            stage_d.op      = id_op;
            stage_d.src0    = fwd_src0;
            stage_d.src1    = fwd_src1;
            stage_d.wreg    = id_wreg;
            stage_d.we      = id_we;
            stage_d.is_load = id_is_load;
            stage_d.valid   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ex_op      = stage_q.op;
    assign ex_src0    = stage_q.src0;
    assign ex_src1    = stage_q.src1;
    assign ex_wreg    = stage_q.wreg;
    assign ex_we      = stage_q.we;
    assign ex_is_load = stage_q.is_load;
    assign ex_valid   = stage_q.valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// Purpose : directed self-checking bench for id_ex_reg against a behavioural model.
// Latency : model expects ex_* one edge after ID inputs; stall_req same cycle.
// Backpr. : exercises hold, flush, flush+hold and load-use bubbles.
module tb_id_ex_reg;
    localparam int OP_W   = 8;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i, hold_i;
    logic [OP_W-1:0]   id_op;
    logic [DATA_W-1:0] id_src0, id_src1;
    logic [REG_AW-1:0] id_rs0_addr, id_rs1_addr, id_wreg;
    logic              id_rs0_rd, id_rs1_rd, id_we, id_is_load;
    logic [DATA_W-1:0] ex_res, mem_res;
    logic [REG_AW-1:0] mem_wreg;
    logic              mem_we;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_src0, ex_src1;
    logic [REG_AW-1:0] ex_wreg;
    logic              ex_we, ex_is_load, ex_valid, stall_req;

    id_ex_reg #(.OP_W(OP_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .hold_i(hold_i),
        .id_op(id_op), .id_src0(id_src0), .id_src1(id_src1),
        .id_rs0_addr(id_rs0_addr), .id_rs0_rd(id_rs0_rd),
        .id_rs1_addr(id_rs1_addr), .id_rs1_rd(id_rs1_rd),
        .id_wreg(id_wreg), .id_we(id_we), .id_is_load(id_is_load),
        .ex_res(ex_res), .mem_wreg(mem_wreg), .mem_we(mem_we), .mem_res(mem_res),
        .ex_op(ex_op), .ex_src0(ex_src0), .ex_src1(ex_src1), .ex_wreg(ex_wreg),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_valid(ex_valid),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model of what sits in the EX slot: one record, described by the
    // instruction it holds rather than by any register structure.
    logic [OP_W-1:0]   m_op;
    logic [DATA_W-1:0] m_src0, m_src1;
    logic [REG_AW-1:0] m_wreg;
    logic              m_we, m_ld, m_vld;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_op = '0; m_src0 = '0; m_src1 = '0; m_wreg = '0; m_we = 1'b0; m_ld = 1'b0; m_vld = 1'b0;
    endtask

    // Load-use: the slot holds a real load writing a nonzero register that ID reads.
    function automatic logic model_stall();
        logic uses;
        uses = (id_rs0_rd && id_rs0_addr == m_wreg) || (id_rs1_rd && id_rs1_addr == m_wreg);
        return m_vld && m_ld && m_we && (m_wreg != 0) && uses;
    endfunction

    // Value an operand must carry: newest producer of the register wins.
    function automatic logic [DATA_W-1:0] model_operand(input logic rd, input logic [REG_AW-1:0] a,
                                                         input logic [DATA_W-1:0] src);
        if (!rd || a == 0) return src;
        if (m_vld && m_we && !m_ld && a == m_wreg) return ex_res;
        if (mem_we && a == mem_wreg) return mem_res;
        return src;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".op"},    64'(ex_op),      64'(m_op));
        chk({tag, ".src0"},  64'(ex_src0),    64'(m_src0));
        chk({tag, ".src1"},  64'(ex_src1),    64'(m_src1));
        chk({tag, ".wreg"},  64'(ex_wreg),    64'(m_wreg));
        chk({tag, ".we"},    64'(ex_we),      64'(m_we));
        chk({tag, ".ld"},    64'(ex_is_load), 64'(m_ld));
        chk({tag, ".valid"}, 64'(ex_valid),   64'(m_vld));
    endtask

    // Called at posedge+1: settle, check stall, predict, clock, check.
    task automatic step(input string tag);
        logic [OP_W-1:0]   n_op;
        logic [DATA_W-1:0] n_s0, n_s1;
        logic [REG_AW-1:0] n_wr;
        logic              n_we, n_ld, n_v, st;
        #1;
        st = model_stall();
        chk({tag, ".stall"}, 64'(stall_req), 64'(st));
        n_op = m_op; n_s0 = m_src0; n_s1 = m_src1; n_wr = m_wreg; n_we = m_we; n_ld = m_ld; n_v = m_vld;
        if (flush_i || (!hold_i && st)) begin
            n_op = '0; n_s0 = '0; n_s1 = '0; n_wr = '0; n_we = 0; n_ld = 0; n_v = 0;
        end else if (!hold_i) begin
            n_op = id_op;
            n_s0 = model_operand(id_rs0_rd, id_rs0_addr, id_src0);
            n_s1 = model_operand(id_rs1_rd, id_rs1_addr, id_src1);
            n_wr = id_wreg; n_we = id_we; n_ld = id_is_load; n_v = 1'b1;
        end
        @(posedge clk);
        #1;
        m_op = n_op; m_src0 = n_s0; m_src1 = n_s1; m_wreg = n_wr; m_we = n_we; m_ld = n_ld; m_vld = n_v;
        check_all(tag);
    endtask

    task automatic set_id(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1,
                          input logic [REG_AW-1:0] a0, input logic r0, input logic [REG_AW-1:0] a1, input logic r1,
                          input logic [REG_AW-1:0] wr, input logic we, input logic ld);
        id_op = op; id_src0 = s0; id_src1 = s1; id_rs0_addr = a0; id_rs0_rd = r0;
        id_rs1_addr = a1; id_rs1_rd = r1; id_wreg = wr; id_we = we; id_is_load = ld;
    endtask

    task automatic set_mem(input logic [REG_AW-1:0] wr, input logic we, input logic [DATA_W-1:0] res);
        mem_wreg = wr; mem_we = we; mem_res = res;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0; ex_res = '0;
        set_id(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_mem(0, 0, 0);
        model_clear();
        #3;
        check_all("reset");
        chk("reset.stall", 64'(stall_req), 64'd0);
        rst_n = 1'b1;

        // EX forward: producer of r3, then consumer of r3.
        set_id(8'h11, 32'h1, 32'h2, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        step("prod_r3");
        ex_res = 32'h1234;
        set_id(8'h12, 32'hDEAD, 32'h44, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0);
        step("ex_fwd");
        chk("ex_fwd.lit", 64'(ex_src0), 64'h1234);

        // EX and MEM both write r5: EX wins; immediate never forwarded; r0 passes.
        ex_res = 32'hAAAA;
        set_mem(5'd5, 1, 32'hBBBB);
        set_id(8'h13, 32'h99, 32'h77, 5'd0, 1, 5'd5, 1, 5'd5, 1, 0);
        step("prio");
        chk("prio.lit", 64'(ex_src1), 64'hAAAA);
        chk("prio.r0",  64'(ex_src0), 64'h99);
        set_id(8'h14, 32'h98, 32'h0010, 5'd9, 1, 5'd5, 0, 5'd0, 1, 0);
        step("imm");
        chk("imm.lit", 64'(ex_src1), 64'h0010);
        // EX now writes r0: a reader of r0 must still take id_src0.
        set_id(8'h15, 32'hCAFE, 32'h5, 5'd0, 1, 5'd5, 1, 5'd6, 1, 0);
        step("r0_pass");
        chk("r0_pass.lit", 64'(ex_src0), 64'hCAFE);
        chk("mem_fwd.lit", 64'(ex_src1), 64'hBBBB);

        // Load-use on r7.
        set_mem(0, 0, 0);
        set_id(8'h21, 32'h100, 32'h8, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1);
        step("load");
        set_id(8'h22, 32'h1, 32'h3, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
        #1;
        chk("lu.stall_lit", 64'(stall_req), 64'd1);
        step("lu_bubble");
        chk("lu.bubble_lit", 64'(ex_valid), 64'd0);
        set_mem(5'd7, 1, 32'h55);
        step("lu_retry");
        chk("lu.src0_lit",  64'(ex_src0),  64'h55);
        chk("lu.valid_lit", 64'(ex_valid), 64'd1);

        // Hold for three cycles with changing ID; outputs frozen at retry values.
        set_mem(0, 0, 0);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(8'h30 + 8'(i), 32'h1000 + i, 32'h2000 + i, 5'd10, 1, 5'd11, 1, 5'd12, 1, 0);
            step("hold");
            chk("hold.op_lit",   64'(ex_op),   64'h22);
            chk("hold.src0_lit", 64'(ex_src0), 64'h55);
        end
        hold_i = 1'b0;
        step("release");
        chk("release.op_lit", 64'(ex_op), 64'h32);

        // Hold while a load-use is pending: stall_req still visible, slot frozen.
        set_id(8'h41, 32'h1, 32'h2, 5'd1, 1, 5'd0, 0, 5'd13, 1, 1);
        step("load2");
        hold_i = 1'b1;
        set_id(8'h42, 32'h3, 32'h4, 5'd0, 0, 5'd13, 1, 5'd14, 1, 0);
        step("hold_stall");
        hold_i = 1'b0;
        step("after_hold_stall");

        // Flush together with hold: flush wins.
        set_id(8'h51, 32'h7, 32'h8, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
        step("valid_again");
        flush_i = 1'b1; hold_i = 1'b1;
        step("flush_hold");
        chk("flush_hold.lit", 64'(ex_valid), 64'd0);
        hold_i = 1'b0;
        step("flush_only");
        flush_i = 1'b0;

        // Asynchronous reset mid-stream.
        step("pre_reset");
        chk("pre_reset.valid_lit", 64'(ex_valid), 64'd1);
        set_id(8'h61, 32'h1, 32'h2, 5'd3, 1, 5'd3, 1, 5'd4, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("arst");
        chk("arst.stall", 64'(stall_req), 64'd0);
        rst_n = 1'b1;
        step("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register directly upstream of the EX stage. Captures decoded op and operands every cycle and presents them to the EX units (logic, arith, shift) as `ex_op`/`ex_src0`/`ex_src1`.
- Resolves RAW hazards by forwarding results from EX and MEM into the operands as they are captured.
- Detects load-use hazards, requests a front-end stall and inserts a bubble.
- Supports downstream hold and control-flow flush.

Parameters:
- OP_W, 8, width of the EX op bus (category field plus concrete field)
- DATA_W, 32, operand/word width
- REG_AW, 5, register address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  kill the instruction being captured (branch/exception)
- hold_i  in  1  downstream stall; freeze all ID/EX contents
- id_op  in  OP_W  decoded EX op
- id_src0  in  DATA_W  operand 0 from regfile
- id_src1  in  DATA_W  operand 1 from regfile or immediate
- id_rs0_addr  in  REG_AW  source reg of src0
- id_rs0_rd  in  1  src0 comes from regfile (forwardable)
- id_rs1_addr  in  REG_AW  source reg of src1
- id_rs1_rd  in  1  src1 comes from regfile (0 = immediate, never forwarded)
- id_wreg  in  REG_AW  destination reg
- id_we  in  1  instruction writes a reg
- id_is_load  in  1  instruction is a load
- ex_res  in  DATA_W  result currently produced by EX
- mem_wreg  in  REG_AW  MEM-stage destination
- mem_we  in  1  MEM-stage write enable
- mem_res  in  DATA_W  MEM-stage result (load data already merged)
- ex_op  out  OP_W  registered op
- ex_src0  out  DATA_W  registered operand 0
- ex_src1  out  DATA_W  registered operand 1
- ex_wreg  out  REG_AW  registered destination
- ex_we  out  1  registered write enable
- ex_is_load  out  1  registered load flag
- ex_valid  out  1  1 = real instruction, 0 = bubble
- stall_req  out  1  combinational request to hold PC and IF/ID

Behaviour:
- Reset (rst_n low, async): all outputs zero (bubble state). `stall_req` is 0 because `ex_is_load` is 0.
- Bubble encoding: op = 0 (NOP), srcs = 0, wreg = 0, we = 0, is_load = 0, valid = 0.
- Forwarding (combinational, per operand, evaluated only when the corresponding `rsN_rd` is 1):
  - If rsN = `ex_wreg`, `ex_we` = 1, `ex_valid` = 1, `ex_is_load` = 0 and rsN ≠ 0, use `ex_res`.
  - Otherwise, if rsN = `mem_wreg`, `mem_we` = 1 and rsN ≠ 0, use `mem_res`.
  - Otherwise, use `id_srcN`.
  - EX has priority over MEM. Register 0 is never forwarded.
- Load-use: `stall_req` = `ex_valid` & `ex_is_load` & `ex_we` & (`ex_wreg` ≠ 0) & ((`id_rs0_rd` & `id_rs0_addr` = `ex_wreg`) | (`id_rs1_rd` & `id_rs1_addr` = `ex_wreg`)). Purely combinational, no latency.
- Update priority on each rising clk edge:
  1. `flush_i` = 1: load bubble.
  2. `hold_i` = 1: keep all registers unchanged. `stall_req` may still assert; the front end ORs it with hold.
  3. `stall_req` = 1: load bubble. The load advances to MEM and the dependent instruction is retried next cycle, then forwarded from MEM.
  4. Otherwise: load forwarded operands and ID fields, with `ex_valid` = 1.
- Flush and hold asserted together: flush wins.
- Latency: one cycle from ID to EX. Max one bubble per load-use.

Test Plan:
- Reset mid-stream: rst_n low while `ex_valid` = 1 → all outputs 0 immediately without a clock; `stall_req` = 0.
- EX forward: `ex_wreg` = 3, `ex_we` = 1, `ex_res` = 0x1234, id rs0 = 3, `id_src0` = 0xDEAD → next `ex_src0` = 0x1234.
- Priority and immediate: EX and MEM both write r5 (`ex_res` = 0xAAAA, `mem_res` = 0xBBBB), rs1 = 5 with `rs1_rd` = 1 → `ex_src1` = 0xAAAA. Repeat with `rs1_rd` = 0 and `id_src1` = 0x0010 → 0x0010. With rs0 = 0 and `ex_wreg` = 0 → `id_src0` passes through.
- Load-use: EX holds a load to r7, ID reads r7:
  - Same cycle: `stall_req` = 1.
  - Next edge: bubble (`ex_valid` = 0).
  - Following cycle: `mem_wreg` = 7, `mem_res` = 0x55 → `ex_src0` = 0x55, `ex_valid` = 1.
- Hold: `hold_i` = 1 for 3 cycles while ID inputs change → outputs constant. Release → captures current ID.
- Flush with hold: `flush_i` = `hold_i` = 1 → bubble loaded next edge.
